arbiter_wrr_burst: RTL and testbench
====================================

// Module: arbiter_wrr_burst
// PURPOSE
//  Credit-based weighted round-robin arbiter for shared-resource ownership.
//  Unlike a per-beat arbiter, a grant is held for a whole multi-beat transaction, until the granted requester's last beat handshakes.
//  Sits in front of a shared bus or port mux; grant_valid/grant_idx drive the mux select.
// PARAMETERS
//  P_REQUESTER_NUM   4   number of requesters (2..16)
//  P_WEIGHT_W        4   credit/weight width in bits
//  P_DEFAULT_WEIGHT  4   reset/fixed weight of every requester (1..2^P_WEIGHT_W-1)
// PORTS
//  clk          in   1                  clock; all logic on rising edge
//  rst_n        in   1                  asynchronous, active-low reset
//  request      in   P_REQUESTER_NUM    per-requester request; held high until its last beat
//  req_last     in   P_REQUESTER_NUM    per-requester last-beat flag, sampled only for the grantee
//  grant_ready  in   1                  resource accepts the current beat
//  grant_valid  out  P_REQUESTER_NUM    one-hot grant, registered
//  grant_idx    out  $clog2(N)          binary index of grantee, valid while |grant_valid
// BEHAVIOUR
//  Reset: grant_valid=0, grant_idx=0, state=IDLE, ptr=0, credit[i]=weight[i]; takes effect immediately, even mid-burst.
//  FSM states:
//   IDLE:
//    - Eligible = request[i] & credit[i]!=0.
//    - If any eligible: pick the first eligible at or after ptr, cyclically.
//    - Next cycle: grant_valid one-hot, grant_idx set -> BURST.
//    - Else if |request: no eligible requester -> REFILL.
//    - Else stay IDLE.
//   BURST:
//    - Grant is held while grant_ready & req_last[g] are not both high.
//    - Request drop mid-burst is a protocol error; the grant is still held.
//    - On grant_ready & req_last[g]: next cycle grant_valid=0, credit[g]-=1, ptr=(g+1) mod N, -> IDLE.
//   REFILL: one cycle, no grant; credit[i]=weight[i] for all i; -> IDLE.
//  Latency:
//   - Request to grant is 1 cycle from IDLE.
//   - Grants are separated by exactly one idle bubble cycle after a last-beat handshake.
//   - A refill adds one more cycle.
//  Credits never underflow: decrement only from nonzero.
//  ptr wraps from N-1 to 0.
//  Single-beat transaction: request & req_last high together; costs 1 credit.
//  grant_ready low in BURST: all state frozen.
//  Weight value 0 is treated as 1.
// CONFIGURATION
//  Macro ARB_WEIGHT_CFG_EN.
//  Defined: extra ports
//   - cfg_we    in 1
//   - cfg_idx   in $clog2(N)
//   - cfg_weight in P_WEIGHT_W
//  Defined, behaviour:
//   - cfg_we writes weight[cfg_idx] <= cfg_weight; weight reset value is P_DEFAULT_WEIGHT.
//   - Live credits are unchanged; a new weight applies at the next REFILL.
//   - cfg_idx >= N is ignored.
//  Undefined: no cfg ports; weight[i] is the constant P_DEFAULT_WEIGHT.
// TESTING
//  T1 (default params)
//   - Stimulus: all 4 request, single-beat, grant_ready=1.
//   - Required: grantee order 0,1,2,3 repeated 4 times; then one REFILL cycle; then 0,1,... again.
//  T2
//   - Stimulus: req0 does a 3-beat burst; req1 requests during it; grant_ready toggles.
//   - Required: grant_valid=0001 until the 3rd accepted beat; one bubble; then 0010.
//  T3 (ARB_WEIGHT_CFG_EN)
//   - Stimulus: weights {3,1,1,1} then force REFILL; all request single-beat.
//   - Required: order 0,1,2,3,0,0; then REFILL.
//  T4
//   - Stimulus: only req2 requests, with weight 4.
//   - Required: 4 grants to 2; REFILL; grants to 2 resume; no grant to others.
//  T5
//   - Stimulus: rst_n asserted mid-burst.
//   - Required: grant_valid=0 asynchronously; after release, credits are full and ptr=0.
//  T6
//   - Stimulus: grant_ready=0 for 10 cycles in BURST.
//   - Required: grant, credits and ptr unchanged.

Source files
------------

// File: rtl/arbiter_wrr_burst.sv
// Credit-based weighted round-robin arbiter; a grant is held for a whole multi-beat transaction.
// Latency: request->grant 1 cycle from IDLE; one bubble cycle after each last beat; a refill adds one cycle.
// Backpressure: grant_ready low during a burst freezes grant, credits and pointer.
// Optional macro ARB_WEIGHT_CFG_EN adds runtime weight programming (cfg_we/cfg_idx/cfg_weight).
module arbiter_wrr_burst #(
  parameter int P_REQUESTER_NUM  = 4,
  parameter int P_WEIGHT_W       = 4,
  parameter int P_DEFAULT_WEIGHT = 4,
  localparam int IDX_W = $clog2(P_REQUESTER_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [P_REQUESTER_NUM-1:0] request,
  input  logic [P_REQUESTER_NUM-1:0] req_last,
  input  logic                       grant_ready,
`ifdef ARB_WEIGHT_CFG_EN
  input  logic                       cfg_we,
  input  logic [IDX_W-1:0]           cfg_idx,
  input  logic [P_WEIGHT_W-1:0]      cfg_weight,
`endif
  output logic [P_REQUESTER_NUM-1:0] grant_valid,
  output logic [IDX_W-1:0]           grant_idx
);

  localparam int N  = P_REQUESTER_NUM;
  localparam int WW = P_WEIGHT_W;
  // one extra bit so ptr + offset can exceed N-1 before wrapping
  localparam int CW = IDX_W + 1;

  localparam logic [WW-1:0]    DEF_W    = WW'(P_DEFAULT_WEIGHT);
  // a zero weight would starve its requester forever, so it counts as one
  localparam logic [WW-1:0]    DEF_EFF  = (DEF_W == '0) ? WW'(1) : DEF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [N-1:0][WW-1:0]    credit_q, credit_d;
  logic [N-1:0]            grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;

  logic [N-1:0][WW-1:0]    weight;
  logic [N-1:0][WW-1:0]    eff_weight;
  logic [N-1:0]            eligible;
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [CW-1:0]           cand_w;
  logic [IDX_W-1:0]        cand;

`ifdef ARB_WEIGHT_CFG_EN
  logic [N-1:0][WW-1:0]    weight_q, weight_d;

  // Weight table update; live credits are untouched until the next refill.
  always_comb begin
    weight_d = weight_q;
    if (cfg_we && (int'(cfg_idx) < N)) begin
      weight_d[cfg_idx] = cfg_weight;
    end
  end

  // Weight table register, reset to the default weight for every requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= {N{DEF_W}};
    end else begin
      weight_q <= weight_d;
    end
  end

  assign weight = weight_q;
`else
  assign weight = {N{DEF_W}};
`endif

  // Effective weight: zero is promoted to one.
  always_comb begin
    eff_weight = '0;
    for (int i = 0; i < N; i++) begin
      eff_weight[i] = (weight[i] == '0) ? WW'(1) : weight[i];
    end
  end

  // A requester may win only while it still has credit left.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = request[i] && (credit_q[i] != '0);
    end
  end

  // Round-robin search: first eligible requester at or after ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_w     = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand_w = {1'b0, ptr_q} + CW'(k);
      if (cand_w >= CW'(N)) begin
        cand_w = cand_w - CW'(N);
      end
      cand = cand_w[IDX_W-1:0];
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state logic for the ownership FSM; all outputs are registered.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_valid_d           = '0;
          grant_valid_d[pick_idx] = 1'b1;
          grant_idx_d             = pick_idx;
          state_d                 = ST_BURST;
        end else if (|request) begin
          // requests pending but every requester is out of credit
          state_d = ST_REFILL;
        end
      end
      ST_BURST: begin
        // ownership ends only on the grantee's accepted last beat;
        // a dropped request mid-burst does not release the grant
        if (grant_ready && req_last[grant_idx_q]) begin
          grant_valid_d = '0;
          if (credit_q[grant_idx_q] != '0) begin
            credit_d[grant_idx_q] = credit_q[grant_idx_q] - 1'b1;
          end
          ptr_d   = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_REFILL: begin
        credit_d = eff_weight;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = '0;
      end
    endcase
  end

  // FSM and output registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      credit_q      <= {N{DEF_EFF}};
      grant_valid_q <= '0;
      grant_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

  // At most one owner, and the index names it whenever a grant is out.
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_valid_q));
  a_grant_idx_match: assert property (@(posedge clk) disable iff (!rst_n)
    (|grant_valid_q) |-> grant_valid_q[grant_idx_q]);

endmodule

// File: tb/tb_arbiter_wrr_burst.sv
// Bench for arbiter_wrr_burst: randomized requester traffic against a transaction-level reference model,
// plus directed grant-order scenarios. Expected per-cycle grants are queued by the model and compared
// by an independent monitor at the falling edge.
module tb_arbiter_wrr_burst;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int DW = 4;
  localparam int IW = $clog2(N);

  typedef struct {
    string name;
    int    act;
    int    exp;
  } dchk_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  request = '0;
  logic [N-1:0]  req_last = '0;
  logic          grant_ready = 1'b0;
  logic [N-1:0]  grant_valid;
  logic [IW-1:0] grant_idx;
`ifdef ARB_WEIGHT_CFG_EN
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [W-1:0]  cfg_weight = '0;
`endif

  int checks = 0;
  int errors = 0;

  arbiter_wrr_burst #(
    .P_REQUESTER_NUM (N),
    .P_WEIGHT_W      (W),
    .P_DEFAULT_WEIGHT(DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .request    (request),
    .req_last   (req_last),
    .grant_ready(grant_ready),
`ifdef ARB_WEIGHT_CFG_EN
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_weight (cfg_weight),
`endif
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int           m_owner = -1;  // current owner, -1 when nobody holds the resource
  bit           m_refill = 1'b0;
  int           m_ptr = 0;
  int           m_credit[N];
  int           m_weight[N];
  int           exp_q[$];      // expected owner for each cycle
  logic [N-1:0] hs_vec = '0;   // beats accepted at the last rising edge
  dchk_t        dq[$];         // directed comparisons handed to the monitor

  function automatic int eff(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  always @(posedge clk) begin
    int pick;
    int c;
    if (!rst_n) begin
      m_owner  = -1;
      m_refill = 1'b0;
      m_ptr    = 0;
      for (int i = 0; i < N; i++) begin
        m_weight[i] = DW;
        m_credit[i] = eff(DW);
      end
      hs_vec = '0;
    end else begin
      hs_vec = grant_ready ? grant_valid : '0;
      if (m_owner >= 0) begin
        if (grant_ready && req_last[m_owner]) begin
          if (m_credit[m_owner] > 0) m_credit[m_owner] = m_credit[m_owner] - 1;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if (m_refill) begin
        for (int i = 0; i < N; i++) m_credit[i] = eff(m_weight[i]);
        m_refill = 1'b0;
      end else begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (pick < 0 && request[c] && m_credit[c] > 0) pick = c;
        end
        if (pick >= 0) m_owner = pick;
        else if (request != '0) m_refill = 1'b1;
      end
`ifdef ARB_WEIGHT_CFG_EN
      if (cfg_we && int'(cfg_idx) < N) m_weight[cfg_idx] = int'(cfg_weight);
`endif
    end
    exp_q.push_back(m_owner);
  end

  // ---------------- monitor / scoreboard ----------------
  int           cyc = 0;
  logic [N-1:0] prev_gv = '0;
  int           seen_idx[$];
  int           seen_start[$];
  int           seen_end[$];

  always @(negedge clk) begin
    int           e;
    logic [N-1:0] ev;
    dchk_t        d;
    cyc = cyc + 1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ev = '0;
      if (e >= 0) ev[e] = 1'b1;
      checks = checks + 1;
      if (grant_valid !== ev) begin
        errors = errors + 1;
        $display("FAIL grant_valid cycle %0d: got %b, expected %b", cyc, grant_valid, ev);
      end
      if (e >= 0) begin
        checks = checks + 1;
        if (grant_idx !== IW'(e)) begin
          errors = errors + 1;
          $display("FAIL grant_idx cycle %0d: got %0d, expected %0d", cyc, grant_idx, e);
        end
      end
    end
    while (dq.size() > 0) begin
      d = dq.pop_front();
      checks = checks + 1;
      if (d.act != d.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %0d, expected %0d", d.name, d.act, d.exp);
      end
    end
    if (grant_valid != '0 && prev_gv == '0) begin
      seen_idx.push_back(int'(grant_idx));
      seen_start.push_back(cyc);
    end
    if (grant_valid == '0 && prev_gv != '0) seen_end.push_back(cyc - 1);
    prev_gv = grant_valid;
  end

  // ---------------- stimulus ----------------
  int           beats[N];  // beats left in each requester's open transaction
  logic [N-1:0] req_mask = '0;
  int           gen_pct = 0;
  int           max_len = 1;
  int           rdy_pct = 100;

  task automatic dpush(input string nm, input int act, input int exp);
    dchk_t d;
    d.name = nm;
    d.act  = act;
    d.exp  = exp;
    dq.push_back(d);
  endtask

  task automatic set_traffic(input logic [N-1:0] m, input int g, input int l, input int r);
    req_mask = m;
    gen_pct  = g;
    max_len  = l;
    rdy_pct  = r;
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (hs_vec[i] && beats[i] > 0) beats[i] = beats[i] - 1;
    for (int i = 0; i < N; i++)
      if (beats[i] == 0 && req_mask[i] && $urandom_range(99) < gen_pct)
        beats[i] = $urandom_range(max_len, 1);
    for (int i = 0; i < N; i++) begin
      request[i]  = (beats[i] != 0);
      req_last[i] = (beats[i] == 1);
    end
    grant_ready = ($urandom_range(99) < rdy_pct);
  endtask

  // Reset asserted between edges so its asynchronous effect is observable.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    dpush("async_reset_grant_valid", int'(grant_valid), 0);
    for (int i = 0; i < N; i++) beats[i] = 0;
    set_traffic('0, 0, 1, 100);
    request     = '0;
    req_last    = '0;
    grant_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_seq(input string nm, input int base, input int el[$]);
    for (int k = 0; k < el.size(); k++) begin
      if (base + k < seen_idx.size()) dpush(nm, seen_idx[base + k], el[k]);
      else dpush(nm, -1, el[k]);
    end
  endtask

  task automatic expect_gap(input string nm, input int i0, input int gap);
    if (i0 + 1 < seen_start.size()) dpush(nm, seen_start[i0 + 1] - seen_start[i0], gap);
    else dpush(nm, -1, gap);
  endtask

  task automatic expect_bubble(input string nm, input int i0, input int bub);
    if (i0 + 1 < seen_start.size() && i0 < seen_end.size())
      dpush(nm, seen_start[i0 + 1] - seen_end[i0] - 1, bub);
    else dpush(nm, -1, bub);
  endtask

  initial begin
    int base;
    int el[$];
    for (int i = 0; i < N; i++) beats[i] = 0;

    // reset state
    @(negedge clk);
    dpush("reset_grant_valid", int'(grant_valid), 0);
    dpush("reset_grant_idx", int'(grant_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: everyone single-beat, always ready
    base = seen_idx.size();
    set_traffic('1, 100, 1, 100);
    repeat (60) step();
    el.delete();
    for (int k = 0; k < 20; k++) el.push_back(k % 4);
    expect_seq("t1_order", base, el);
    expect_gap("t1_gap_plain", base, 2);
    expect_gap("t1_gap_refill", base + 15, 4);

`ifdef ARB_WEIGHT_CFG_EN
    // T3: weights 3,1,1,1 take effect at the refill after the default credits drain
    apply_reset();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      cfg_we     = 1'b1;
      cfg_idx    = IW'(i);
      cfg_weight = (i == 0) ? W'(3) : W'(1);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    base = seen_idx.size();
    set_traffic('1, 100, 1, 100);
    repeat (70) step();
    el.delete();
    for (int k = 0; k < 16; k++) el.push_back(k % 4);
    el.push_back(0); el.push_back(1); el.push_back(2); el.push_back(3);
    el.push_back(0); el.push_back(0); el.push_back(1);
    expect_seq("t3_order", base, el);
    expect_gap("t3_gap_refill", base + 21, 4);
`endif

    // T2: 3-beat burst from req0 with req1 queued behind it, ready toggling
    apply_reset();
    base = seen_idx.size();
    set_traffic('0, 0, 1, 50);
    beats[0] = 3;
    step();
    beats[1] = 1;
    step();
    repeat (40) step();
    el.delete();
    el.push_back(0); el.push_back(1);
    expect_seq("t2_order", base, el);
    expect_bubble("t2_bubble", base, 1);

    // T4: only req2 requests
    apply_reset();
    base = seen_idx.size();
    set_traffic(4'b0100, 100, 1, 100);
    repeat (30) step();
    el.delete();
    for (int k = 0; k < 6; k++) el.push_back(2);
    expect_seq("t4_order", base, el);
    expect_gap("t4_gap_plain", base, 2);
    expect_gap("t4_gap_refill", base + 3, 4);

    // T5: reset mid-burst, then full credits and ptr 0
    apply_reset();
    set_traffic('0, 0, 1, 0);
    beats[0] = 6;
    repeat (4) step();
    dpush("t5_grant_before_reset", int'(grant_valid), 1);
    apply_reset();
    base = seen_idx.size();
    set_traffic('1, 100, 1, 100);
    repeat (50) step();
    el.delete();
    for (int k = 0; k < 16; k++) el.push_back(k % 4);
    expect_seq("t5_order", base, el);
    expect_gap("t5_gap_refill", base + 15, 4);

    // T6: grant_ready low for more than 10 cycles inside a burst
    apply_reset();
    base = seen_idx.size();
    set_traffic('0, 0, 1, 0);
    beats[1] = 2;
    repeat (12) step();
    set_traffic('0, 0, 1, 100);
    repeat (4) step();
    set_traffic('1, 100, 1, 100);
    repeat (50) step();
    el.delete();
    el.push_back(1);
    for (int r = 0; r < 3; r++) begin
      el.push_back(2); el.push_back(3); el.push_back(0); el.push_back(1);
    end
    el.push_back(2); el.push_back(3); el.push_back(0); el.push_back(1);
    expect_seq("t6_order", base, el);
    if (base < seen_end.size() && base < seen_start.size())
      dpush("t6_hold_cycles", seen_end[base] - seen_start[base] + 1, 13);
    else dpush("t6_hold_cycles", -1, 13);
    expect_gap("t6_gap_refill", base + 15, 4);

    // random traffic against the model
    apply_reset();
    set_traffic('1, 30, 4, 70);
    repeat (1500) step();
    set_traffic('1, 80, 3, 40);
    repeat (800) step();
    set_traffic(4'b1010, 60, 5, 90);
    repeat (400) step();

    set_traffic('0, 0, 1, 100);
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
